// File: rtl/bypass_rf_sequencer_pkg.sv
// Shared types for the bypass register-file sequencer: FSM state encoding and
// the reservation "go" predicate.
package bypass_rf_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RES,
    WAIT,
    OUT,
    WB,
    FREE
  } seq_state_t;

  // Reservation may only fire when every port it needs is ready in the same cycle.
  function automatic logic rres_go(input logic rres_rdy_1,
                                   input logic rres_rdy_2,
                                   input logic alloc_rdy,
                                   input logic has_rd);
    return rres_rdy_1 & rres_rdy_2 & (alloc_rdy | ~has_rd);
  endfunction

endpackage

// File: rtl/bypass_rf_sequencer.sv
// Single-op-in-flight sequencer: reserves RF names, collects operands, forwards
// them downstream, writes the result back and frees the names again.
module bypass_rf_sequencer
  import bypass_rf_sequencer_pkg::*;
#(
  parameter int unsigned addr_width = 1,
  parameter int unsigned data_width = 1,
  parameter int unsigned name_width = 1
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  REQ_VALID,
  output logic                  REQ_RDY,
  input  logic [addr_width-1:0] REQ_RS1,
  input  logic [addr_width-1:0] REQ_RS2,
  input  logic [addr_width-1:0] REQ_RD,
  input  logic                  REQ_HASRD,

  output logic                  OP_VALID,
  input  logic                  OP_RDY,
  output logic [data_width-1:0] OP_A,
  output logic [data_width-1:0] OP_B,

  input  logic                  WB_VALID,
  output logic                  WB_RDY,
  input  logic [data_width-1:0] WB_DATA,

  output logic [addr_width-1:0] RF_ADDR_IN,
  output logic                  RF_ALLOC_E,
  input  logic                  RF_ALLOC_READY,
  input  logic [name_width-1:0] RF_NAME_OUT,
  output logic [addr_width-1:0] RF_ADDR_1,
  output logic                  RF_RRESE_1,
  input  logic                  RF_RRES_READY_1,
  input  logic [name_width-1:0] RF_RNAME_OUT_1,
  output logic [addr_width-1:0] RF_ADDR_2,
  output logic                  RF_RRESE_2,
  input  logic                  RF_RRES_READY_2,
  input  logic [name_width-1:0] RF_RNAME_OUT_2,

  output logic [name_width-1:0] RF_NAME_IN_1,
  output logic [data_width-1:0] RF_D_IN_1,
  output logic                  RF_WE_1,
  output logic                  RF_WE_2,
  output logic [name_width-1:0] RF_NAME_1,
  output logic [name_width-1:0] RF_VALID_NAME_1,
  input  logic [data_width-1:0] RF_D_OUT_1,
  input  logic                  RF_VALID_OUT_1,
  output logic [name_width-1:0] RF_NAME_2,
  output logic [name_width-1:0] RF_VALID_NAME_2,
  input  logic [data_width-1:0] RF_D_OUT_2,
  input  logic                  RF_VALID_OUT_2,

  output logic [name_width-1:0] RF_W_F,
  output logic                  RF_WFE,
  input  logic                  RF_F_READY,
  output logic [name_width-1:0] RF_RD_F_1,
  output logic                  RF_FE_1,
  output logic [name_width-1:0] RF_RD_F_2,
  output logic                  RF_FE_2
);

  seq_state_t state_q, state_d;

  logic [addr_width-1:0] rs1_q, rs1_d;
  logic [addr_width-1:0] rs2_q, rs2_d;
  logic [addr_width-1:0] rd_q, rd_d;
  logic                  hasrd_q, hasrd_d;
  logic [name_width-1:0] rn1_q, rn1_d;
  logic [name_width-1:0] rn2_q, rn2_d;
  logic [name_width-1:0] wn_q, wn_d;
  logic [data_width-1:0] op_a_q, op_a_d;
  logic [data_width-1:0] op_b_q, op_b_d;
  logic                  got1_q, got1_d;
  logic                  got2_q, got2_d;
  logic                  rd_freed_q, rd_freed_d;
  logic                  wr_freed_q, wr_freed_d;
  logic                  go;

  assign go      = rres_go(RF_RRES_READY_1, RF_RRES_READY_2, RF_ALLOC_READY, hasrd_q);
  assign OP_A    = op_a_q;
  assign OP_B    = op_b_q;
  assign RF_WE_2 = 1'b0;

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    hasrd_d    = hasrd_q;
    rn1_d      = rn1_q;
    rn2_d      = rn2_q;
    wn_d       = wn_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    got1_d     = got1_q;
    got2_d     = got2_q;
    rd_freed_d = rd_freed_q;
    wr_freed_d = wr_freed_q;

    REQ_RDY         = 1'b0;
    OP_VALID        = 1'b0;
    WB_RDY          = 1'b0;
    RF_ADDR_IN      = '0;
    RF_ALLOC_E      = 1'b0;
    RF_ADDR_1       = '0;
    RF_RRESE_1      = 1'b0;
    RF_ADDR_2       = '0;
    RF_RRESE_2      = 1'b0;
    RF_NAME_IN_1    = '0;
    RF_D_IN_1       = '0;
    RF_WE_1         = 1'b0;
    RF_NAME_1       = '0;
    RF_VALID_NAME_1 = '0;
    RF_NAME_2       = '0;
    RF_VALID_NAME_2 = '0;
    RF_W_F          = '0;
    RF_WFE          = 1'b0;
    RF_RD_F_1       = '0;
    RF_FE_1         = 1'b0;
    RF_RD_F_2       = '0;
    RF_FE_2         = 1'b0;

    case (state_q)
      IDLE: begin
        REQ_RDY = 1'b1;
        if (REQ_VALID) begin
          rs1_d   = REQ_RS1;
          rs2_d   = REQ_RS2;
          rd_d    = REQ_RD;
          hasrd_d = REQ_HASRD;
          state_d = RES;
        end
      end

      RES: begin
        RF_ADDR_1  = rs1_q;
        RF_ADDR_2  = rs2_q;
        RF_ADDR_IN = rd_q;
        // All three enables share one condition so a reservation is never partial.
        if (go) begin
          RF_RRESE_1 = 1'b1;
          RF_RRESE_2 = 1'b1;
          RF_ALLOC_E = hasrd_q;
          rn1_d      = RF_RNAME_OUT_1;
          rn2_d      = RF_RNAME_OUT_2;
          wn_d       = RF_NAME_OUT;
          got1_d     = 1'b0;
          got2_d     = 1'b0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        RF_NAME_1       = rn1_q;
        RF_VALID_NAME_1 = rn1_q;
        RF_NAME_2       = rn2_q;
        RF_VALID_NAME_2 = rn2_q;
        if (!got1_q && RF_VALID_OUT_1) begin
          op_a_d = RF_D_OUT_1;
          got1_d = 1'b1;
        end
        if (!got2_q && RF_VALID_OUT_2) begin
          op_b_d = RF_D_OUT_2;
          got2_d = 1'b1;
        end
        if (got1_d && got2_d) begin
          state_d = OUT;
        end
      end

      OUT: begin
        OP_VALID = 1'b1;
        if (OP_RDY) begin
          rd_freed_d = 1'b0;
          wr_freed_d = 1'b0;
          state_d    = hasrd_q ? WB : FREE;
        end
      end

      WB: begin
        WB_RDY       = 1'b1;
        RF_WE_1      = WB_VALID;
        RF_NAME_IN_1 = wn_q;
        RF_D_IN_1    = WB_DATA;
        if (WB_VALID) begin
          state_d = FREE;
        end
      end

      FREE: begin
        RF_RD_F_1 = rn1_q;
        RF_RD_F_2 = rn2_q;
        if (!rd_freed_q) begin
          RF_FE_1    = 1'b1;
          RF_FE_2    = 1'b1;
          rd_freed_d = 1'b1;
        end
        if (hasrd_q && !wr_freed_q) begin
          RF_WFE = 1'b1;
          RF_W_F = wn_q;
          if (RF_F_READY) begin
            wr_freed_d = 1'b1;
          end
        end
        // Using the _d flags lets read and write frees retire in the same cycle.
        if (rd_freed_d && (wr_freed_d || !hasrd_q)) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      hasrd_q    <= 1'b0;
      rn1_q      <= '0;
      rn2_q      <= '0;
      wn_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      got1_q     <= 1'b0;
      got2_q     <= 1'b0;
      rd_freed_q <= 1'b0;
      wr_freed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      hasrd_q    <= hasrd_d;
      rn1_q      <= rn1_d;
      rn2_q      <= rn2_d;
      wn_q       <= wn_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      got1_q     <= got1_d;
      got2_q     <= got2_d;
      rd_freed_q <= rd_freed_d;
      wr_freed_q <= wr_freed_d;
    end
  end

endmodule
